// File: rtl/data_memory.sv
// Block-addressed main data memory serving data-cache refills and write-backs.
// One 128-bit block request at a time, fixed access latency, registered read data.
module data_memory #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 4
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         MEM_READ,
  input  logic         MEM_WRITE,
  input  logic [27:0]  MEM_ADDRESS,
  input  logic [127:0] MEM_WRITEDATA,
  output logic [127:0] MEM_READDATA,
  output logic         MEM_BUSYWAIT
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(LATENCY) + 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [127:0]    wdata_q, wdata_d;
  logic [127:0]    rdata_q, rdata_d;
  logic            mem_we;
  logic            busy;

  logic [127:0]    mem_q [DEPTH];

  // Upper block-address bits alias onto the same storage.
  logic            unused_addr;
  assign unused_addr = ^MEM_ADDRESS[27:IdxW];

  // Next-state logic: latch the request in IDLE, count down in ACCESS, one DONE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    busy    = 1'b0;
    case (state_q)
      StIdle: begin
        busy = MEM_READ | MEM_WRITE;
        if (MEM_READ || MEM_WRITE) begin
          // A simultaneous read+write is a write only.
          wr_d    = MEM_WRITE;
          idx_d   = MEM_ADDRESS[IdxW-1:0];
          wdata_d = MEM_WRITEDATA;
          cnt_d   = CntLoad;
          state_d = StAccess;
        end
      end
      StAccess: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          state_d = StDone;
          if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_q[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        busy    = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control and latched-request state; reset abandons any in-flight access.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign MEM_READDATA = rdata_q;
  assign MEM_BUSYWAIT = busy;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory (DEPTH=256, LATENCY=4).
module tb_data_memory;

  logic         CLK;
  logic         RESET_N;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int n_asserts = 0;
  int n_fail    = 0;

  localparam int unsigned Lat = 4;

  localparam logic [127:0] DatW1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] DatP  = 128'hA5A5A5A5_11112222_33334444_5A5A5A5A;
  localparam logic [127:0] DatQ  = 128'h0F0F0F0F_DEADBEEF_CAFEBABE_F0F0F0F0;
  localparam logic [127:0] DatA  = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
  localparam logic [127:0] DatB  = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
  localparam logic [127:0] DatE  = 128'h01010101_02020202_03030303_04040404;
  localparam logic [127:0] DatC  = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
  localparam logic [127:0] DatD1 = 128'h99990000_88881111_77772222_66663333;
  localparam logic [127:0] DatD2 = 128'h55554444_33332222_11110000_EEEEDDDD;

  data_memory #(
    .DEPTH   (256),
    .LATENCY (Lat)
  ) u_dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Called 1ns after a rising edge with the DUT in IDLE. Returns mid-DONE with
  // requests dropped; nbusy counts mid-cycle samples with MEM_BUSYWAIT high.
  task automatic run_req(input logic rd, input logic wr, input logic [27:0] addr,
                         input logic [127:0] data, input logic chg,
                         input logic [27:0] chg_addr, input logic [127:0] chg_data,
                         output int nbusy, output logic rdata_moved);
    logic [127:0] rd_before;
    rd_before     = MEM_READDATA;
    rdata_moved   = 1'b0;
    nbusy         = 0;
    MEM_READ      = rd;
    MEM_WRITE     = wr;
    MEM_ADDRESS   = addr;
    MEM_WRITEDATA = data;
    for (int i = 0; i < 16; i++) begin
      if (i == 2 && chg) begin
        MEM_ADDRESS   = chg_addr;
        MEM_WRITEDATA = chg_data;
      end
      #4;
      if (MEM_READDATA !== rd_before) rdata_moved = 1'b1;
      if (!MEM_BUSYWAIT) break;
      nbusy++;
      step();
    end
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
  endtask

  int   nb;
  logic moved;

  initial begin
    RESET_N       = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;

    // Reset with no request.
    #12;
    check("rst_rdata", MEM_READDATA, '0);
    check("rst_busy_idle", 128'(MEM_BUSYWAIT), 128'(0));
    MEM_READ = 1'b1;
    #1;
    check("rst_busy_req", 128'(MEM_BUSYWAIT), 128'(1));
    MEM_READ = 1'b0;
    #9;
    RESET_N = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      #4;
      check("post_rst_busy", 128'(MEM_BUSYWAIT), 128'(0));
      step();
    end

    // Write then read the same block.
    run_req(1'b0, 1'b1, 28'h0000012, DatW1, 1'b0, '0, '0, nb, moved);
    check("wr12_busy_cycles", 128'(nb), 128'(Lat + 1));
    step();
    run_req(1'b1, 1'b0, 28'h0000012, '0, 1'b0, '0, '0, nb, moved);
    check("rd12_busy_cycles", 128'(nb), 128'(Lat + 1));
    check("rd12_data_done", MEM_READDATA, DatW1);
    step();
    check("rd12_data_hold", MEM_READDATA, DatW1);

    // Back-to-back write-back then refill from a different block.
    run_req(1'b0, 1'b1, 28'h15, DatP, 1'b0, '0, '0, nb, moved);
    step();
    run_req(1'b0, 1'b1, 28'h05, DatQ, 1'b0, '0, '0, nb, moved);
    check("wb05_busy_cycles", 128'(nb), 128'(Lat + 1));
    check("wb05_rdata_unchanged", 128'(moved), 128'(0));
    step();
    run_req(1'b1, 1'b0, 28'h15, '0, 1'b0, '0, '0, nb, moved);
    check("refill15_busy_cycles", 128'(nb), 128'(Lat + 1));
    check("refill15_data", MEM_READDATA, DatP);
    step();

    // Input changes during ACCESS must not affect the latched write.
    run_req(1'b0, 1'b1, 28'h08, DatE, 1'b0, '0, '0, nb, moved);
    step();
    run_req(1'b0, 1'b1, 28'h07, DatA, 1'b1, 28'h08, DatB, nb, moved);
    check("chg_busy_cycles", 128'(nb), 128'(Lat + 1));
    step();
    run_req(1'b1, 1'b0, 28'h07, '0, 1'b0, '0, '0, nb, moved);
    check("chg_rd07", MEM_READDATA, DatA);
    step();
    run_req(1'b1, 1'b0, 28'h08, '0, 1'b0, '0, '0, nb, moved);
    check("chg_rd08", MEM_READDATA, DatE);
    step();

    // Simultaneous read and write acts as a write only.
    run_req(1'b1, 1'b1, 28'h03, DatC, 1'b0, '0, '0, nb, moved);
    check("rw_busy_cycles", 128'(nb), 128'(Lat + 1));
    check("rw_rdata_unchanged", 128'(moved), 128'(0));
    check("rw_rdata_value", MEM_READDATA, DatE);
    step();
    run_req(1'b1, 1'b0, 28'h03, '0, 1'b0, '0, '0, nb, moved);
    check("rw_rd03", MEM_READDATA, DatC);
    step();

    // Reset in the second ACCESS cycle of a write abandons it.
    run_req(1'b0, 1'b1, 28'h09, DatD1, 1'b0, '0, '0, nb, moved);
    step();
    MEM_WRITE     = 1'b1;
    MEM_ADDRESS   = 28'h09;
    MEM_WRITEDATA = DatD2;
    step();
    step();
    #1;
    RESET_N = 1'b0;
    #1;
    check("midrst_rdata_async", MEM_READDATA, '0);
    check("midrst_busy_req", 128'(MEM_BUSYWAIT), 128'(1));
    MEM_WRITE = 1'b0;
    #1;
    check("midrst_busy_noreq", 128'(MEM_BUSYWAIT), 128'(0));
    step();
    step();
    #3;
    RESET_N = 1'b1;
    step();
    run_req(1'b1, 1'b0, 28'h109, '0, 1'b0, '0, '0, nb, moved);
    check("midrst_busy_cycles", 128'(nb), 128'(Lat + 1));
    check("midrst_rd109_alias", MEM_READDATA, DatD1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
